// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle control FSM for the Fibonacci RV32I-subset core
// Sequences fetch/decode/execute/memory/write-back and drives datapath enables and selects.
module mc_control_fsm #(
  parameter int unsigned RESET_IDLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_src,
  output logic       ir_we,
  output logic       pc_we,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       halt,
  output logic       illegal
);

  localparam logic [1:0] ALU_TO_PRF         = 2'd0;
  localparam logic [1:0] DATA_OUT_TO_PRF    = 2'd1;
  localparam logic [1:0] INSTRUCTION_TO_PRF = 2'd2;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  localparam logic [3:0] IDLE_LAST = 4'(RESET_IDLE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_ALU_WB, S_MEM_ADDR,
    S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JAL, S_HALT
  } state_t;

  state_t     r_state;
  logic [3:0] r_idle_cnt;
  logic       r_halt;
  logic       r_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idle_cnt <= '0;
      r_halt     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_idle_cnt >= IDLE_LAST) r_state <= S_FETCH;
          else r_idle_cnt <= r_idle_cnt + 4'd1;
        end
        S_FETCH:     if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_R, OP_I, OP_LUI: r_state <= S_EXECUTE;
            OP_LW, OP_SW:       r_state <= S_MEM_ADDR;
            OP_BR:              r_state <= S_BRANCH;
            OP_JAL:             r_state <= S_JAL;
            OP_SYS: begin
              r_state <= S_HALT;
              r_halt  <= 1'b1;
            end
            default: begin
              r_state   <= S_HALT;
              r_halt    <= 1'b1;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_EXECUTE:   r_state <= S_ALU_WB;
        S_ALU_WB:    r_state <= S_FETCH;
        S_MEM_ADDR:  r_state <= (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WB:    r_state <= S_FETCH;
        S_MEM_WRITE: if (mem_ready) r_state <= S_FETCH;
        S_BRANCH:    r_state <= S_FETCH;
        S_JAL:       r_state <= S_FETCH;
        S_HALT:      r_state <= S_HALT;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode; only FETCH (mem_ready) and BRANCH (zero/funct3) look at inputs
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_src  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_op    = 2'd0;
    rf_we     = 1'b0;
    wb_sel    = ALU_TO_PRF;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd2;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
      end
      S_EXECUTE: begin
        alu_src_a = (opcode == OP_LUI) ? 2'd3 : 2'd2;
        alu_src_b = (opcode == OP_R) ? 2'd0 : 2'd1;
        alu_op    = (opcode == OP_LUI) ? 2'd0 : 2'd2;
      end
      S_ALU_WB:    rf_we = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
      end
      S_MEM_READ: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
      end
      S_MEM_WB: begin
        rf_we  = 1'b1;
        wb_sel = DATA_OUT_TO_PRF;
      end
      S_MEM_WRITE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_src = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 2'd2;
        alu_op    = 2'd1;
        pc_src    = 1'b1;
        pc_we     = (funct3 == 3'b000) ? zero : ((funct3 == 3'b001) ? !zero : 1'b0);
      end
      S_JAL: begin
        rf_we  = 1'b1;
        wb_sel = INSTRUCTION_TO_PRF;
        pc_we  = 1'b1;
        pc_src = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign halt    = r_halt;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - self-checking bench for mc_control_fsm
// Expands each instruction into its expected per-cycle output trace and compares every cycle.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, addr_src, ir_we, pc_we, pc_src, rf_we, halt, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;

  int n_cmp = 0;
  int n_err = 0;
  string cur = "";

  always #5 clk = ~clk;

  mc_control_fsm #(.RESET_IDLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel),
    .halt(halt), .illegal(illegal)
  );

  typedef struct packed {
    logic       mem_req, mem_we, addr_src, ir_we, pc_we, pc_src;
    logic [1:0] a, b, op;
    logic       rf_we;
    logic [1:0] wb;
    logic       halt, illegal;
  } outs_t;

  typedef struct packed {
    logic  rdy;
    outs_t o;
  } cyc_t;

  cyc_t q[$];

  function automatic outs_t actual();
    outs_t o;
    o.mem_req = mem_req; o.mem_we = mem_we; o.addr_src = addr_src; o.ir_we = ir_we;
    o.pc_we = pc_we; o.pc_src = pc_src; o.a = alu_src_a; o.b = alu_src_b; o.op = alu_op;
    o.rf_we = rf_we; o.wb = wb_sel; o.halt = halt; o.illegal = illegal;
    return o;
  endfunction

  task automatic check(input string name, input outs_t e);
    outs_t a;
    a = actual();
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h (fields req,we,as,ir,pcwe,pcs,a,b,op,rf,wb,h,il)", name, a, e);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic push(input logic rdy, input outs_t o);
    cyc_t c;
    c.rdy = rdy;
    c.o = o;
    q.push_back(c);
  endtask

  task automatic add_fetch_wait(input int stall);
    outs_t o = '0;
    o.mem_req = 1'b1; o.b = 2'd2;
    for (int i = 0; i < stall; i++) push(1'b0, o);
  endtask

  // One whole instruction, from its first FETCH cycle to its last cycle
  task automatic build(input logic [6:0] opc, input logic [2:0] f3, input logic zr,
                       input int fstall, input int mstall, input int hold);
    outs_t o;
    add_fetch_wait(fstall);
    o = '0; o.mem_req = 1'b1; o.b = 2'd2; o.ir_we = 1'b1; o.pc_we = 1'b1;
    push(1'b1, o);
    o = '0; o.a = 2'd1; o.b = 2'd1;
    push(1'b1, o);
    case (opc)
      7'b0110011, 7'b0010011, 7'b0110111: begin
        o = '0;
        if (opc == 7'b0110111) begin o.a = 2'd3; o.b = 2'd1; o.op = 2'd0; end
        else begin o.a = 2'd2; o.b = (opc == 7'b0010011) ? 2'd1 : 2'd0; o.op = 2'd2; end
        push(1'b1, o);
        o = '0; o.rf_we = 1'b1; o.wb = 2'd0;
        push(1'b1, o);
      end
      7'b0000011, 7'b0100011: begin
        o = '0; o.a = 2'd2; o.b = 2'd1;
        push(1'b1, o);
        o = '0; o.mem_req = 1'b1; o.addr_src = 1'b1; o.mem_we = (opc == 7'b0100011);
        for (int i = 0; i < mstall; i++) push(1'b0, o);
        push(1'b1, o);
        if (opc == 7'b0000011) begin
          o = '0; o.rf_we = 1'b1; o.wb = 2'd1;
          push(1'b1, o);
        end
      end
      7'b1100011: begin
        o = '0; o.a = 2'd2; o.b = 2'd0; o.op = 2'd1; o.pc_src = 1'b1;
        o.pc_we = (f3 == 3'd0 && zr) || (f3 == 3'd1 && !zr);
        push(1'b1, o);
      end
      7'b1101111: begin
        o = '0; o.rf_we = 1'b1; o.wb = 2'd2; o.pc_we = 1'b1; o.pc_src = 1'b1;
        push(1'b1, o);
      end
      default: begin
        o = '0; o.halt = 1'b1; o.illegal = (opc != 7'b1110011);
        for (int i = 0; i < hold; i++) push(i[0], o);
      end
    endcase
  endtask

  task automatic drain(output int n);
    cyc_t c;
    n = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      mem_ready = c.rdy;
      #1;
      check($sformatf("%s_c%0d", cur, n), c.o);
      n++;
    end
  endtask

  task automatic instr(input string name, input logic [6:0] opc, input logic [2:0] f3,
                       input logic zr, input int fstall, input int mstall, input int want);
    int n;
    cur = name;
    opcode = opc; funct3 = f3; zero = zr;
    build(opc, f3, zr, fstall, mstall, 20);
    drain(n);
    check_int({name, "_cycles"}, n, want);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1;
    #1 check({name, "_asserted"}, '0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1 check({name, "_idle"}, '0);
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_held", '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("idle_after_release", '0);

    cur = "fetch_wait";
    opcode = 7'b0110011;
    add_fetch_wait(2);
    drain(n);
    do_reset("reset_in_fetch");

    instr("add",      7'b0110011, 3'd0, 1'b0, 0, 0, 4);
    instr("addi",     7'b0010011, 3'd0, 1'b0, 1, 0, 5);
    instr("lui",      7'b0110111, 3'd0, 1'b0, 0, 0, 4);
    instr("lw_stall", 7'b0000011, 3'd2, 1'b0, 0, 3, 8);
    instr("lw",       7'b0000011, 3'd2, 1'b0, 0, 0, 5);
    instr("sw",       7'b0100011, 3'd2, 1'b0, 0, 0, 4);
    instr("sw_stall", 7'b0100011, 3'd2, 1'b0, 2, 2, 8);
    instr("beq_t",    7'b1100011, 3'd0, 1'b1, 0, 0, 3);
    instr("beq_nt",   7'b1100011, 3'd0, 1'b0, 0, 0, 3);
    instr("bne_t",    7'b1100011, 3'd1, 1'b0, 0, 0, 3);
    instr("bne_nt",   7'b1100011, 3'd1, 1'b1, 0, 0, 3);
    instr("br_f3_4",  7'b1100011, 3'd4, 1'b1, 0, 0, 3);
    instr("jal",      7'b1101111, 3'd0, 1'b0, 0, 0, 3);
    instr("illegal",  7'b1111111, 3'd0, 1'b0, 0, 0, 22);
    do_reset("reset_after_illegal");
    instr("ecall",    7'b1110011, 3'd0, 1'b0, 0, 0, 22);
    do_reset("reset_after_ecall");
    instr("add_post", 7'b0110011, 3'd0, 1'b0, 0, 0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle control unit for the Fibonacci RV32I-subset core.
- Sequences each instruction through fetch, decode, execute, memory and write-back.
- Drives all datapath enables and selects, including `wb_sel`, which is the select of the downstream 3-to-1 register-file write-back mux.
- Talks to the unified instruction/data memory through a req/ready handshake.

Parameters:
- `RESET_IDLE_CYCLES`, 1: cycles spent in IDLE after reset release before the first FETCH (legal range 1..15).

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  7  `ir[6:0]` from instruction register
- `funct3`  in  3  `ir[14:12]`
- `zero`  in  1  ALU zero flag, combinational, current cycle
- `mem_ready`  in  1  memory completes current request this cycle
- `mem_req`  out  1  memory request valid
- `mem_we`  out  1  request is a write
- `addr_src`  out  1  memory address: 0=PC, 1=ALU-out register
- `ir_we`  out  1  load instruction register
- `pc_we`  out  1  load PC
- `pc_src`  out  1  PC next: 0=ALU result (PC+4), 1=ALU-out register (target)
- `alu_src_a`  out  2  0=PC, 1=old PC, 2=rs1, 3=zero
- `alu_src_b`  out  2  0=rs2, 1=imm, 2=constant 4
- `alu_op`  out  2  0=ADD, 1=SUB, 2=decode by funct fields
- `rf_we`  out  1  register file write enable
- `wb_sel`  out  2  write-back select; shared-define codes ALU_TO_PRF, DATA_OUT_TO_PRF, INSTRUCTION_TO_PRF
- `halt`  out  1  core halted (sticky until reset)
- `illegal`  out  1  halt was caused by an unsupported opcode (sticky)

Behaviour:
- **Reset.** `rst_n` low immediately forces state IDLE and clears the idle counter, `halt` and `illegal`.
  - All outputs are 0 in IDLE; `wb_sel` = ALU_TO_PRF.
  - Reset mid-transaction drops `mem_req` asynchronously.
- **Output decoding.** Outputs are decoded from state only, except BRANCH `pc_we` (depends on `zero`, `funct3`) and the `mem_ready`-qualified enables in FETCH.
- **IDLE.** Remain `RESET_IDLE_CYCLES` cycles, then go to FETCH.
- **FETCH.**
  - Drives `mem_req=1`, `addr_src=0`, `alu_src_a=0`, `alu_src_b=2`, `alu_op=0`.
  - Holds while `mem_ready=0`.
  - On `mem_ready=1`: `ir_we=1`, `pc_we=1`, `pc_src=0`, then go to DECODE.
- **DECODE.** One cycle; ALU computes branch/jump target (`alu_src_a=1`, `alu_src_b=1`, ADD) into the ALU-out register. Dispatch on `opcode`:
  - 0110011 (R) or 0010011 (I-ALU): EXECUTE
  - 0110111 (LUI): EXECUTE
  - 0000011 (LW) or 0100011 (SW): MEM_ADDR
  - 1100011: BRANCH
  - 1101111: JAL
  - 1110011: HALT
  - any other opcode: HALT with `illegal=1`
- **EXECUTE.** One cycle, then ALU_WB.
  - R-type: `a=2`, `b=0`, `op=2`.
  - I-type: `a=2`, `b=1`, `op=2`.
  - LUI: `a=3`, `b=1`, `op=0`.
- **ALU_WB.** `rf_we=1`, `wb_sel=ALU_TO_PRF`, then FETCH.
- **MEM_ADDR.** `a=2`, `b=1`, `op=0`; go to MEM_READ for LW, MEM_WRITE for SW.
- **MEM_READ.** `mem_req=1`, `addr_src=1`; hold until `mem_ready`, then MEM_WB.
- **MEM_WB.** `rf_we=1`, `wb_sel=DATA_OUT_TO_PRF`, then FETCH.
- **MEM_WRITE.** `mem_req=1`, `mem_we=1`, `addr_src=1`; hold until `mem_ready`, then FETCH.
- **BRANCH.** One cycle: `a=2`, `b=0`, `op=1`, `pc_src=1`, then FETCH.
  - `pc_we = zero` if `funct3==000` (BEQ).
  - `pc_we = !zero` if `funct3==001` (BNE).
  - Any other `funct3`: not taken, no halt.
- **JAL.** One cycle, then FETCH: `rf_we=1`, `wb_sel=INSTRUCTION_TO_PRF` (link value from PC path), `pc_we=1`, `pc_src=1`.
- **HALT.** Absorbing: `halt=1`, all enables 0, `mem_req=0`; exits only via reset.
- **Cycle counts** (ready in first cycle, FETCH included):
  - R/I/LUI: 4
  - LW: 5
  - SW: 4
  - BRANCH: 3
  - JAL: 3
- **Handshake rules.**
  - `mem_ready` while `mem_req=0` is ignored.
  - `mem_req`, `mem_we` and `addr_src` remain stable while waiting.
  - `mem_req` deasserts in the cycle after the accepting edge, because the next state differs.
- **Invariants.**
  - `rf_we` and `mem_we` are never both 1.
  - `ir_we` is only ever 1 in FETCH.
- Unreachable state encodings recover to IDLE.

Test Plan:
- Reset release with `RESET_IDLE_CYCLES=1` -> one IDLE cycle with all outputs 0, then `mem_req=1` and `addr_src=0` from cycle 2; assert `rst_n` low during FETCH -> `mem_req=0` before the next edge.
- ADD `opcode=0110011`, `mem_ready=1` -> FETCH, DECODE, EXECUTE(`a=2`, `b=0`, `op=2`), ALU_WB(`rf_we=1`, `wb_sel=ALU_TO_PRF`); next `mem_req=1` on cycle 5.
- LW with memory stalling 3 cycles in MEM_READ -> `mem_req` and `addr_src=1` held for 4 cycles, then MEM_WB with `rf_we=1`, `wb_sel=DATA_OUT_TO_PRF`; total 8 cycles.
- BEQ `funct3=000` with `zero=1` -> `pc_we=1`, `pc_src=1`; same with `zero=0` -> `pc_we=0`; BNE with `zero=0` -> `pc_we=1`.
- JAL -> single cycle with `rf_we=1`, `wb_sel=INSTRUCTION_TO_PRF`, `pc_we=1`, `pc_src=1`.
- Opcode 1111111 -> HALT with `halt=1`, `illegal=1`, `mem_req=0` held for 20 cycles despite `mem_ready` toggling; ECALL -> `halt=1`, `illegal=0`; reset clears both.
